// File: rtl/lpc_reg_pkg.sv
// Shared constants for the LPC register bank: register addresses,
// lock-state encoding and default parameter values.
package lpc_reg_pkg;

    localparam logic [7:0] ADDR_ID     = 8'h00;
    localparam logic [7:0] ADDR_LOCK   = 8'h01;
    localparam logic [7:0] ADDR_STATUS = 8'h02;
    localparam logic [7:0] ADDR_IRQEN  = 8'h03;
    localparam logic [7:0] ADDR_BIOS   = 8'h04;
    localparam int         FIRST_SCR   = 5;

    localparam logic [7:0] DEF_ID_VALUE = 8'h10;
    localparam logic [7:0] DEF_KEY0     = 8'h55;
    localparam logic [7:0] DEF_KEY1     = 8'hAA;

    // Encoding is visible to software through the LOCK register.
    typedef enum logic [1:0] {
        LOCK_LOCKED   = 2'd0,
        LOCK_ARMED    = 2'd1,
        LOCK_UNLOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/lpc_pwrok_sync.sv
// Two-flop synchroniser for the asynchronous power-good input, with a
// one-cycle pulse on each rising edge of the synchronised level.
module lpc_pwrok_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwr_ok,
    output logic pwr_sync,
    output logic pwr_rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= pwr_ok;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign pwr_sync = sync_r;
    assign pwr_rise = sync_r & ~prev_r;

endmodule

// File: rtl/lpc_reg_bank.sv
// LPC-side register bank: ID, key-sequence lock, sticky W1C event status
// with maskable interrupt, BIOS-select hand-over on power-good, scratch.
module lpc_reg_bank
    import lpc_reg_pkg::*;
#(
    parameter int         NUM_REGS = 32,
    parameter int         ADDR_W   = 8,
    parameter int         DATA_W   = 8,
    parameter int         EVT_W    = 8,
    parameter logic [7:0] ID_VALUE = DEF_ID_VALUE,
    parameter logic [7:0] KEY0     = DEF_KEY0,
    parameter logic [7:0] KEY1     = DEF_KEY1
) (
    input  logic              LpcClock,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [DATA_W-1:0] DataWr,
    output logic [DATA_W-1:0] DataRd,
    output logic              RdValid,
    input  logic              Pwr_ok,
    input  logic [EVT_W-1:0]  Event,
    output logic              Active_Bios,
    output logic              Irq,
    output logic              Locked
);

    localparam int NUM_SCR = NUM_REGS - FIRST_SCR;

    lock_state_e       lock_state_r;
    logic              locked_r;
    logic [EVT_W-1:0]  status_r;
    logic [DATA_W-1:0] irq_en_r;
    logic              active_r;
    logic              next_r;
    logic              irq_r;
    logic [DATA_W-1:0] data_rd_r;
    logic              rd_valid_r;
    logic [DATA_W-1:0] scratch_r [NUM_SCR];

    logic              pwr_sync_s;
    logic              pwr_rise_s;
    logic              addr_impl_s;
    logic              hit_lock_s;
    logic              hit_status_s;
    logic              hit_irqen_s;
    logic              hit_bios_s;
    logic              unlocked_s;
    logic              key0_s;
    logic              key1_s;
    logic [EVT_W-1:0]  clr_s;
    logic [DATA_W-1:0] scr_rd_s;
    logic [DATA_W-1:0] rd_val_s;

    lpc_pwrok_sync u_pwrok_sync (
        .clk      (LpcClock),
        .rst_n    (rst_n),
        .pwr_ok   (Pwr_ok),
        .pwr_sync (pwr_sync_s),
        .pwr_rise (pwr_rise_s)
    );

    assign addr_impl_s  = (int'(Addr) < NUM_REGS);
    assign hit_lock_s   = (Addr == ADDR_W'(ADDR_LOCK));
    assign hit_status_s = (Addr == ADDR_W'(ADDR_STATUS));
    assign hit_irqen_s  = (Addr == ADDR_W'(ADDR_IRQEN));
    assign hit_bios_s   = (Addr == ADDR_W'(ADDR_BIOS));
    assign unlocked_s   = (lock_state_r == LOCK_UNLOCKED);
    assign key0_s       = (DataWr == DATA_W'(KEY0));
    assign key1_s       = (DataWr == DATA_W'(KEY1));
    assign clr_s        = (Wr && hit_status_s) ? DataWr[EVT_W-1:0] : {EVT_W{1'b0}};

    // Lock FSM: KEY0 then KEY1 to LOCK unlocks; any stray write while armed relocks.
    always_ff @(posedge LpcClock or negedge rst_n) begin
        if (!rst_n) begin
            lock_state_r <= LOCK_LOCKED;
            locked_r     <= 1'b1;
        end else begin
            case (lock_state_r)
                LOCK_LOCKED: begin
                    if (Wr && hit_lock_s && key0_s) begin
                        lock_state_r <= LOCK_ARMED;
                    end
                    locked_r <= 1'b1;
                end
                LOCK_ARMED: begin
                    if (Wr) begin
                        if (hit_lock_s && key1_s) begin
                            lock_state_r <= LOCK_UNLOCKED;
                            locked_r     <= 1'b0;
                        end else begin
                            lock_state_r <= LOCK_LOCKED;
                            locked_r     <= 1'b1;
                        end
                    end
                end
                LOCK_UNLOCKED: begin
                    if (Wr && hit_lock_s) begin
                        lock_state_r <= LOCK_LOCKED;
                        locked_r     <= 1'b1;
                    end
                end
                default: begin
                    lock_state_r <= LOCK_LOCKED;
                    locked_r     <= 1'b1;
                end
            endcase
        end
    end

    // Sticky event status (set beats clear) and the registered interrupt.
    always_ff @(posedge LpcClock or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= {EVT_W{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            status_r <= Event | (status_r & ~clr_s);
            irq_r    <= |(status_r & irq_en_r[EVT_W-1:0]);
        end
    end

    // Protected registers: interrupt enable and BIOS select; power-good edge owns bit0.
    always_ff @(posedge LpcClock or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_r <= {DATA_W{1'b0}};
            active_r <= 1'b0;
            next_r   <= 1'b0;
        end else begin
            if (Wr && hit_irqen_s && unlocked_s) begin
                irq_en_r <= DataWr;
            end
            if (Wr && hit_bios_s && unlocked_s) begin
                next_r <= DataWr[1];
            end
            if (pwr_rise_s) begin
                active_r <= next_r;
            end else if (Wr && hit_bios_s && unlocked_s) begin
                active_r <= DataWr[0];
            end
        end
    end

    // Unprotected scratch registers.
    always_ff @(posedge LpcClock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SCR; i++) begin
                scratch_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_SCR; i++) begin
                if (Wr && (Addr == ADDR_W'(i + FIRST_SCR))) begin
                    scratch_r[i] <= DataWr;
                end
            end
        end
    end

    // Read multiplexer over the pre-write register contents.
    always_comb begin
        scr_rd_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_SCR; i++) begin
            scr_rd_s = scr_rd_s |
                       ((Addr == ADDR_W'(i + FIRST_SCR)) ? scratch_r[i] : {DATA_W{1'b0}});
        end
        rd_val_s = {DATA_W{1'b1}};
        if (!addr_impl_s) begin
            rd_val_s = {DATA_W{1'b1}};
        end else begin
            case (Addr)
                ADDR_W'(ADDR_ID):     rd_val_s = DATA_W'(ID_VALUE);
                ADDR_W'(ADDR_LOCK):   rd_val_s = DATA_W'(lock_state_r);
                ADDR_W'(ADDR_STATUS): rd_val_s = DATA_W'(status_r);
                ADDR_W'(ADDR_IRQEN):  rd_val_s = irq_en_r;
                ADDR_W'(ADDR_BIOS):   rd_val_s = DATA_W'({pwr_sync_s, next_r, active_r});
                default:              rd_val_s = scr_rd_s;
            endcase
        end
    end

    // Registered read data (held between reads) and its valid pulse.
    always_ff @(posedge LpcClock or negedge rst_n) begin
        if (!rst_n) begin
            data_rd_r  <= {DATA_W{1'b1}};
            rd_valid_r <= 1'b0;
        end else begin
            if (Rd) begin
                data_rd_r <= rd_val_s;
            end
            rd_valid_r <= Rd;
        end
    end

    assign DataRd      = data_rd_r;
    assign RdValid     = rd_valid_r;
    assign Irq         = irq_r;
    assign Locked      = locked_r;
    assign Active_Bios = active_r;

endmodule

// File: tb/tb_lpc_reg_bank.sv
// Directed bench for lpc_reg_bank with a behavioural register-map model
// compared against the outputs on every falling clock edge.
module tb_lpc_reg_bank;

    logic       clk;
    logic       rst_n;
    logic [7:0] Addr;
    logic       Rd;
    logic       Wr;
    logic [7:0] DataWr;
    logic [7:0] DataRd;
    logic       RdValid;
    logic       Pwr_ok;
    logic [7:0] Event;
    logic       Active_Bios;
    logic       Irq;
    logic       Locked;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    lpc_reg_bank dut (
        .LpcClock    (clk),
        .rst_n       (rst_n),
        .Addr        (Addr),
        .Rd          (Rd),
        .Wr          (Wr),
        .DataWr      (DataWr),
        .DataRd      (DataRd),
        .RdValid     (RdValid),
        .Pwr_ok      (Pwr_ok),
        .Event       (Event),
        .Active_Bios (Active_Bios),
        .Irq         (Irq),
        .Locked      (Locked)
    );

    initial begin
        clk = 1'b0;
        forever #15 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_status = 8'h00;
    logic [7:0] m_irqen  = 8'h00;
    logic [7:0] m_drd    = 8'hFF;
    logic [7:0] m_scr [256];
    logic       m_act = 1'b0, m_next = 1'b0, m_rv = 1'b0, m_irq = 1'b0, m_locked = 1'b1;
    int         m_lock = 0;
    logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;   // Pwr_ok samples at the last three edges

    function automatic logic [7:0] mread(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h10;
            8'h01:   return 8'(m_lock);
            8'h02:   return m_status;
            8'h03:   return m_irqen;
            8'h04:   return {5'b00000, h2, m_next, m_act};
            default: return (a < 8'd32) ? m_scr[a] : 8'hFF;
        endcase
    endfunction

    task automatic model_reset();
        m_status = 8'h00; m_irqen = 8'h00; m_drd = 8'hFF;
        m_act = 1'b0; m_next = 1'b0; m_rv = 1'b0; m_irq = 1'b0; m_locked = 1'b1;
        m_lock = 0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        for (int i = 0; i < 256; i++) m_scr[i] = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] rv;
        logic [7:0] clr;
        logic       rise, unl, old_next;
        rv       = mread(Addr);
        rise     = h2 & ~h3;
        unl      = (m_lock == 2);
        old_next = m_next;
        m_irq    = |(m_status & m_irqen);
        if (Rd) m_drd = rv;
        m_rv = Rd;
        clr  = 8'h00;
        if (Wr) begin
            if (Addr == 8'h02) clr = DataWr;
            if (Addr == 8'h03 && unl) m_irqen = DataWr;
            if (Addr == 8'h04 && unl) begin
                m_next = DataWr[1];
                m_act  = DataWr[0];
            end
            if (Addr >= 8'd5 && Addr < 8'd32) m_scr[Addr] = DataWr;
            if (m_lock == 1) m_lock = (Addr == 8'h01 && DataWr == 8'hAA) ? 2 : 0;
            else if (Addr == 8'h01) m_lock = (m_lock == 0 && DataWr == 8'h55) ? 1 : 0;
        end
        if (rise) m_act = old_next;
        m_status = (m_status & ~clr) | Event;
        m_locked = (m_lock != 2);
        h3 = h2; h2 = h1; h1 = Pwr_ok;
    endtask

    // Model advances on the same edges as the design, including async reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Compare every output with the model on each falling edge.
    always @(negedge clk) begin
        check("m_datard", DataRd, m_drd);
        check("m_rdvalid", {7'b0, RdValid}, {7'b0, m_rv});
        check("m_irq", {7'b0, Irq}, {7'b0, m_irq});
        check("m_locked", {7'b0, Locked}, {7'b0, m_locked});
        check("m_active", {7'b0, Active_Bios}, {7'b0, m_act});
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic r, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] ev);
        @(negedge clk);
        Rd = r; Wr = w; Addr = a; DataWr = d; Event = ev;
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0; Event = 8'h00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        op(1'b0, 1'b1, a, d, 8'h00);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
        op(1'b1, 1'b0, a, 8'h00, 8'h00);
        check(name, DataRd, exp);
        check({name, "_valid"}, {7'b0, RdValid}, 8'h01);
    endtask

    initial begin
        rst_n = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 8'h00; DataWr = 8'h00;
        Event = 8'h00; Pwr_ok = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_datard", DataRd, 8'hFF);
        check("rst_locked", {7'b0, Locked}, 8'h01);
        check("rst_irq", {7'b0, Irq}, 8'h00);
        check("rst_active", {7'b0, Active_Bios}, 8'h00);

        rd_chk(8'h00, 8'h10, "rd_id");
        rd_chk(8'h04, 8'h00, "rd_bios_rst");
        rd_chk(8'h1F, 8'h00, "rd_last_scr");
        rd_chk(8'h20, 8'hFF, "rd_unimpl");
        rd_chk(8'h01, 8'h00, "rd_lock_rst");

        // Locked write is dropped, then unlock and write succeeds.
        wr(8'h04, 8'h03);
        check("locked_wr_active", {7'b0, Active_Bios}, 8'h00);
        rd_chk(8'h04, 8'h00, "locked_wr_bios");
        wr(8'h01, 8'h55);
        wr(8'h01, 8'hAA);
        rd_chk(8'h01, 8'h02, "lock_unlocked");
        check("unlocked_pin", {7'b0, Locked}, 8'h00);
        wr(8'h04, 8'h03);
        check("unlocked_wr_active", {7'b0, Active_Bios}, 8'h01);

        // Relock sequence with interleaved scratch write.
        wr(8'h01, 8'h55);
        wr(8'h05, 8'h12);
        wr(8'h01, 8'hAA);
        rd_chk(8'h01, 8'h00, "lock_relocked");
        rd_chk(8'h05, 8'h12, "scratch_05");
        op(1'b1, 1'b1, 8'h05, 8'h34, 8'h00);
        check("rd_wr_same_cycle", DataRd, 8'h12);
        rd_chk(8'h05, 8'h34, "scratch_after_wr");

        // Event status and interrupt.
        wr(8'h01, 8'h55);
        wr(8'h01, 8'hAA);
        wr(8'h03, 8'h08);
        op(1'b0, 1'b0, 8'h00, 8'h00, 8'h08);
        check("irq_not_yet", {7'b0, Irq}, 8'h00);
        @(negedge clk);
        check("irq_two_cycles", {7'b0, Irq}, 8'h01);
        rd_chk(8'h02, 8'h08, "status_set");
        op(1'b0, 1'b1, 8'h02, 8'h08, 8'h08);
        rd_chk(8'h02, 8'h08, "set_wins_clear");
        wr(8'h02, 8'h08);
        rd_chk(8'h02, 8'h00, "status_cleared");
        op(1'b0, 1'b0, 8'h00, 8'h00, 8'h04);
        rd_chk(8'h02, 8'h04, "status_masked");
        check("irq_masked", {7'b0, Irq}, 8'h00);

        // BIOS hand-over on power-good rise.
        wr(8'h04, 8'h02);
        rd_chk(8'h04, 8'h02, "bios_next_set");
        @(negedge clk); Pwr_ok = 1'b1;
        @(negedge clk); check("pwr_c1", {7'b0, Active_Bios}, 8'h00);
        @(negedge clk); check("pwr_c2", {7'b0, Active_Bios}, 8'h00);
        @(negedge clk); check("pwr_c3", {7'b0, Active_Bios}, 8'h01);
        rd_chk(8'h04, 8'h07, "bios_after_rise");
        Pwr_ok = 1'b0;
        repeat (5) @(negedge clk);
        check("pwr_fall_hold", {7'b0, Active_Bios}, 8'h01);
        rd_chk(8'h04, 8'h03, "bios_after_fall");

        // Async reset in the middle of a read while unlocked.
        op(1'b0, 1'b0, 8'h00, 8'h00, 8'h08);
        @(negedge clk);
        Rd = 1'b1; Addr = 8'h05;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_datard", DataRd, 8'hFF);
        check("arst_locked", {7'b0, Locked}, 8'h01);
        check("arst_irq", {7'b0, Irq}, 8'h00);
        check("arst_rdvalid", {7'b0, RdValid}, 8'h00);
        Rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk(8'h02, 8'h00, "arst_status");
        rd_chk(8'h01, 8'h00, "arst_lock");
        rd_chk(8'h05, 8'h00, "arst_scratch");
        rd_chk(8'h03, 8'h00, "arst_irqen");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
